lc3b_iter_alu: RTL



---
 rtl/lc3b_iter_alu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lc3b_iter_alu.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_iter_alu
// Purpose  : Multi-cycle LC-3b ALU. Add/and/not/pass finish in one edge.
//            Shifts run iteratively, at most STEP bits per cycle, under a
//            start/busy/done handshake. The result and its NZP flags are
//            registered.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_iter_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       aluop_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       nzp_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         nzp_q, nzp_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_single;
  logic [31:0]        w_cnt_ext;
  logic [31:0]        w_step_amt;
  logic [WIDTH-1:0]   w_shifted;

  // Flags of a result: negative, zero, positive (exactly one set).
  function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] v);
    logic n, z;
    n = v[WIDTH-1];
    z = (v == '0);
    return {n, z, ~n & ~z};
  endfunction

  // Decode the incoming request and compute the one-edge result.
  always_comb begin
    w_shamt    = b_i[SHAMT_W-1:0];
    w_is_shift = (aluop_i == OP_SLL) || (aluop_i == OP_SRL) || (aluop_i == OP_SRA);
    case (aluop_i)
      OP_ADD:  w_single = a_i + b_i;
      OP_AND:  w_single = a_i & b_i;
      OP_NOT:  w_single = ~a_i;
      default: w_single = a_i;   // pass, reserved, and zero-length shifts
    endcase
  end

  // One shift step of min(STEP, cnt) bits on the latched accumulator.
  always_comb begin
    w_cnt_ext  = 32'(cnt_q);
    w_step_amt = (w_cnt_ext < 32'(STEP)) ? w_cnt_ext : 32'(STEP);
    case (op_q)
      OP_SLL:  w_shifted = acc_q << w_step_amt;
      OP_SRA:  w_shifted = $unsigned($signed(acc_q) >>> w_step_amt);
      default: w_shifted = acc_q >> w_step_amt;
    endcase
  end

  // Next-state logic: accept requests in IDLE, iterate shifts in SHIFT.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    nzp_d    = nzp_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (w_is_shift && (w_shamt != '0)) begin
            acc_d   = a_i;
            cnt_d   = w_shamt;
            op_d    = aluop_i;
            state_d = ST_SHIFT;
          end else begin
            result_d = w_single;
            nzp_d    = f_nzp(w_single);
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        acc_d = w_shifted;
        cnt_d = cnt_q - SHAMT_W'(w_step_amt);
        if (cnt_d == '0) begin
          result_d = w_shifted;
          nzp_d    = f_nzp(w_shifted);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  // State registers; reset discards any in-flight shift.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      nzp_q    <= 3'b000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      nzp_q    <= nzp_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == ST_SHIFT);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign nzp_o    = nzp_q;

endmodule
`default_nettype wire
